seg_7_func: RTL and testbench

- Registered 4-bit-to-7-segment decoder.
- Takes a nibble on four discrete inputs (A = MSB, D = LSB) and drives a 7-segment glyph pattern on seg_7.
- Covers BCD digits 0-9 and hex glyphs A-F, with lamp-test and blanking overrides.
- Sits between button/switch or counter logic and the board's display pins.

---
 rtl/seg_7_func.sv | 77 +++++++
 tb/tb_seg_7_func.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg_7_func.sv
// seg_7_func: registered 4-bit to 7-segment decoder (digits 0-9, hex A-F).
// Priority is lamp_test > blank > decode of {A,B,C,D}, with a one-cycle latency.
// seg_7 is {a,b,c,d,e,f,g}; by default a 1 lights a segment.
// Optional macro SEG7_ACTIVE_LOW_EN inverts every output value, including the
// reset value, for common-anode displays.
module seg_7_func (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] seg_7
);

`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0] PolMask = 7'h7F;
`else
    localparam logic [6:0] PolMask = 7'h00;
`endif

    logic [3:0] nibble;
    logic [6:0] glyph;
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    assign nibble = {A, B, C, D};

    // Glyph lookup in active-high form; every code is defined.
    always_comb begin
        glyph = 7'h00;
        unique case (nibble)
            4'h0: glyph = 7'h7E;
            4'h1: glyph = 7'h30;
            4'h2: glyph = 7'h6D;
            4'h3: glyph = 7'h79;
            4'h4: glyph = 7'h33;
            4'h5: glyph = 7'h5B;
            4'h6: glyph = 7'h5F;
            4'h7: glyph = 7'h70;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h7B;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h1F;
            4'hC: glyph = 7'h4E;
            4'hD: glyph = 7'h3D;
            4'hE: glyph = 7'h4F;
            4'hF: glyph = 7'h47;
            default: glyph = 7'h00;
        endcase
    end

    // Apply the overrides, then the output polarity, before the register.
    always_comb begin
        seg_d = glyph;
        if (lamp_test) begin
            seg_d = 7'h7F;
        end else if (blank) begin
            seg_d = 7'h00;
        end
        seg_d = seg_d ^ PolMask;
    end

    // Output register; reset clears the display (all segments off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= PolMask;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_7 = seg_q;

endmodule

// File: tb/tb_seg_7_func.sv
// Testbench for seg_7_func. It runs directed checks with literal expectations
// and random traffic checked every cycle against a behavioural model.
module tb_seg_7_func;

`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'h7F;
`else
    localparam logic [6:0] INV = 7'h00;
`endif
    localparam logic [6:0] RST = 7'h00 ^ INV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic       blank = 1'b0, lamp_test = 1'b0;
    logic [6:0] seg_7;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic [6:0] model_q = 7'h00 ^ INV;

    seg_7_func dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .blank     (blank),
        .lamp_test (lamp_test),
        .seg_7     (seg_7)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] expect_of(input logic [3:0] n, input logic bl,
                                             input logic lt);
        logic [6:0] v;
        if (lt)      v = 7'h7F;
        else if (bl) v = 7'h00;
        else         v = glyph_tab[n];
        return v ^ INV;
    endfunction

    // Reference: what the display should show, one edge behind the inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_q <= RST;
        else        model_q <= expect_of({A, B, C, D}, blank, lamp_test);
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (seg_7 !== model_q) begin
                n_bad++;
                $display("FAIL model t=%0t seg_7=%h required=%h", $time, seg_7, model_q);
            end
        end
    end

    task automatic check(input string name, input logic [6:0] req);
        n_cmp++;
        if (seg_7 !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t seg_7=%h required=%h", name, $time, seg_7, req);
        end
    endtask

    task automatic drive(input logic [3:0] n, input logic bl, input logic lt);
        {A, B, C, D} = n;
        blank = bl;
        lamp_test = lt;
    endtask

    // Drive inputs now, then land 1 time unit after the next rising edge.
    task automatic step(input logic [3:0] n, input logic bl, input logic lt);
        drive(n, bl, lt);
        @(posedge clk);
        #1;
    endtask

    logic [6:0] bcd_exp [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B};
    logic [6:0] hex_exp [6]  = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    initial begin
        // Reset held with N=8 and clocks running.
        #1;
        drive(4'h8, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_async", RST);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", RST);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 7'h7F ^ INV);
        chk_en = 1'b1;

        // BCD sweep with a mid-stream asynchronous reset pulse.
        for (int i = 0; i < 10; i++) begin
            step(4'(i), 1'b0, 1'b0);
            check($sformatf("bcd_%0d", i), bcd_exp[i] ^ INV);
            if (i == 5) begin
                rst_n = 1'b0;
                #1;
                check("midreset_async", RST);
                #2;
                rst_n = 1'b1;
                step(4'h6, 1'b0, 1'b0);
                check("midreset_resume", 7'h5F ^ INV);
            end
        end

        // Hex sweep.
        for (int i = 0; i < 6; i++) begin
            step(4'(i + 10), 1'b0, 1'b0);
            check($sformatf("hex_%0d", i + 10), hex_exp[i] ^ INV);
        end

        // Overrides.
        step(4'h3, 1'b1, 1'b0);
        check("blank", 7'h00 ^ INV);
        step(4'h3, 1'b1, 1'b1);
        check("lamp_over_blank", 7'h7F ^ INV);
        step(4'h3, 1'b0, 1'b0);
        check("release_overrides", 7'h79 ^ INV);
        step(4'h0, 1'b0, 1'b0);
        check("digit0_pol", 7'h7E ^ INV);

        // Random traffic, with occasional reset pulses between edges.
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 31) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_reset", RST);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout t=%0t seg_7=%h required=finish", $time, seg_7);
        $fatal(1);
    end

endmodule
